// File: rtl/cv32e41p_arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Pure declarations: no latency, no flow control.
package cv32e41p_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e41p_ff_one.sv
// Find-first-one: lowest set index of in_i, plus an all-zero flag.
// Purely combinational, zero latency, no flow control.
module cv32e41p_ff_one
  import cv32e41p_arb_pkg::*;
#(
  parameter  int unsigned LEN   = 4,
  localparam int unsigned IDX_W = arb_idx_w(LEN)
) (
  input  logic [LEN-1:0]   in_i,
  output logic [IDX_W-1:0] first_one_o,
  output logic             no_ones_o
);

  // Scan downward so the lowest set bit is written last and wins.
  always_comb begin
    first_one_o = '0;
    for (int i = int'(LEN) - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IDX_W'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e41p_rr_arbiter.sv
// Round-robin owner of one multi-cycle resource: 1-cycle registered grant, then busy until done/flush/timeout.
// Requests are only sampled when the resource is free; later requesters simply wait at their level.
module cv32e41p_rr_arbiter
  import cv32e41p_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned TIMEOUT = 0,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  input  logic               flush_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic               timeout_d;

  logic [NUM_REQ-1:0] mask, masked;
  logic [IDX_W-1:0]   masked_idx, raw_idx, win_idx;
  logic               masked_none, raw_none;
  logic               arb_en;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      mask[i] = (IDX_W'(i) >= ptr_q);
    end
  end

  assign masked = req_i & mask;

  cv32e41p_ff_one #(.LEN(NUM_REQ)) u_ff_masked (
    .in_i        (masked),
    .first_one_o (masked_idx),
    .no_ones_o   (masked_none)
  );

  cv32e41p_ff_one #(.LEN(NUM_REQ)) u_ff_raw (
    .in_i        (req_i),
    .first_one_o (raw_idx),
    .no_ones_o   (raw_none)
  );

  // Nothing at or above the pointer: wrap around to the lowest raw request.
  assign win_idx = masked_none ? raw_idx : masked_idx;

  // A done in the grant cycle itself is not a completion.
  assign arb_en = (state_q == ARB_IDLE) |
                  ((state_q == ARB_BUSY) & done_i & ~|gnt_o & ~flush_i);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    gnt_idx_d = gnt_idx_o;
    timeout_d = 1'b0;
    if (arb_en) begin
      cnt_d = '0;
      if (raw_none) begin
        state_d = ARB_IDLE;
      end else begin
        state_d   = ARB_BUSY;
        gnt_d     = NUM_REQ'(1) << win_idx;
        gnt_idx_d = win_idx;
        ptr_d     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
    end else if (state_q == ARB_BUSY) begin
      if (flush_i) begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
        state_d   = ARB_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_o     <= gnt_d;
      gnt_idx_o <= gnt_idx_d;
      timeout_o <= timeout_d;
    end
  end

  assign busy_o = (state_q == ARB_BUSY);

endmodule
